ofdm_cp_remover: RTL and testbench
==================================

// Module: ofdm_cp_remover
// PURPOSE
//  Consumes the sc16 stream from the Schmidl-Cox detector. The detector marks the timing point with tuser=1.
//  On each trigger, the block strips the cyclic prefix from NUM_SYMBOLS OFDM symbols.
//  It emits each FFT_LEN-sample body as one AXIS packet to the downstream FFT.
//  All samples outside a triggered frame are discarded.
// PARAMETERS
//  MAX_FFT_LOG2  12  log2 of the largest supported FFT length; sizes the counters
//  MAX_CP_W      12  width of the cp_len config input
//  MAX_SYM_W      8  width of the num_symbols config input
// PORTS
//  ce_clk          in   1             block clock
//  ce_rst          in   1             synchronous active-high reset
//  cfg_fft_len     in   MAX_FFT_LOG2+1  FFT length in samples (8..2^MAX_FFT_LOG2)
//  cfg_cp_len      in   MAX_CP_W      CP length in samples (0 allowed)
//  cfg_num_symbols in   MAX_SYM_W     symbols per frame (0 treated as 1)
//  s_axis_tdata    in   32            sample: I=[31:16], Q=[15:0]
//  s_axis_tuser    in   1             1 = timing point (first CP sample of symbol 0)
//  s_axis_tvalid   in   1             input valid
//  s_axis_tready   out  1             input ready
//  m_axis_tdata    out  32            symbol-body sample
//  m_axis_tuser    out  1             1 on first sample of first symbol of a frame
//  m_axis_tlast    out  1             1 on last sample of each symbol
//  m_axis_tvalid   out  1             output valid
//  m_axis_tready   in   1             output ready
//  busy            out  1             1 while not in IDLE
//  frame_count     out  16            frames started; wraps at 2^16
//  overlap_count   out  16            triggers ignored mid-frame; saturates at 0xFFFF
// BEHAVIOUR
//  Reset values: m_axis_tvalid/tuser/tlast=0; m_axis_tdata=0; busy=0; counters=0; state=IDLE.
//  Reset mid-frame: any partial symbol is dropped with no tlast. Output is idle on the cycle after ce_rst.
//  Input handshake:
//   - s_axis_tready=1 in IDLE and SKIP_CP (samples are sunk).
//   - In PASS, s_axis_tready = !m_axis_tvalid || m_axis_tready.
//  Output is a single register stage:
//   - Latency is 1 cycle from input accept to m_axis_tvalid.
//   - tdata/tuser/tlast hold stable while tvalid && !tready.
//  Config is sampled only on the accepted trigger beat in IDLE and held for the whole frame.
//  State IDLE:
//   - Accepted beat with tuser=1: latch config, frame_count++, sym_cnt=0, first=1.
//   - If cp_len>0: that beat is CP sample 0, samp_cnt=1, go to SKIP_CP.
//   - If cp_len==0: that beat is body sample 0 and is output, samp_cnt=1, go to PASS.
//  State SKIP_CP:
//   - Each accepted beat is dropped, samp_cnt++.
//   - When samp_cnt reaches cp_len after an accept: samp_cnt=0, go to PASS.
//  State PASS:
//   - Each accepted beat is registered to the output.
//   - tuser=first on body sample 0; first clears after that beat.
//   - tlast=1 when samp_cnt==fft_len-1.
//  End of symbol (after the tlast beat is accepted into the output register):
//   - sym_cnt++.
//   - If sym_cnt==num_symbols: go to IDLE.
//   - Else samp_cnt=0 and go to SKIP_CP, or stay in PASS when cp_len==0.
//  Triggers outside IDLE: input tuser=1 in SKIP_CP/PASS is ignored, the sample is treated as ordinary data, and overlap_count++.
//  A trigger on the same beat that ends a frame is also counted as overlap and does not restart a frame.
//  Width rules:
//   - samp_cnt is MAX_FFT_LOG2+1 bits; compares are unsigned.
//   - fft_len=2^MAX_FFT_LOG2 must work.
//  Output back-pressure in PASS stalls input; no samples are lost.
//  Back-pressure in SKIP_CP/IDLE is never exerted.
// TESTING
//  1. Basic frame.
//     Stimulus: fft=16, cp=4, sym=2; ramp input 0..99 with tuser on sample 10.
//     Response: outputs 14..29 (tlast@29, tuser@14), then 34..49 (tlast@49); busy=0 after; frame_count=1.
//  2. cp=0, fft=8, sym=1; trigger on sample 5 -> outputs 5..12, tuser@5, tlast@12.
//  3. Back-pressure: case 1 with random m_axis_tready (50%) and input tvalid gaps -> identical output sequence, no drops or duplicates.
//  4. Overlap.
//     Stimulus: case 1 plus an extra tuser on sample 20.
//     Response: output unchanged; overlap_count=1; frame_count=1.
//  5. Reset mid-frame: assert ce_rst for 1 cycle after output 20 -> tvalid=0 next cycle; busy=0; a new trigger then frames correctly.
//  6. Config change mid-frame: write fft=32 during case 1 -> frame still uses 16; next frame uses 32.

Source files
------------

// File: rtl/ofdm_cp_remover.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_cp_remover
// Description : Strips the cyclic prefix from the OFDM symbols that follow a
//               Schmidl-Cox timing trigger. It forwards each FFT_LEN-sample
//               symbol body as one AXI-Stream packet, using tlast on the last
//               body sample and tuser on the first body sample of a frame.
//               Samples outside a triggered frame are discarded.
//
// Ports       : ce_clk, ce_rst          clock, synchronous active-high reset
//               cfg_fft_len/cp_len/
//               cfg_num_symbols         frame config, latched on the trigger
//               s_axis_*                sc16 input stream (tuser = trigger)
//               m_axis_*                symbol-body output stream
//               busy                    high while a frame is in progress
//               frame_count             frames started (wraps)
//               overlap_count           triggers ignored mid-frame (saturates)
// Revision    : 1.0 - initial release
// ============================================================================
module ofdm_cp_remover #(
    parameter int MAX_FFT_LOG2 = 12,
    parameter int MAX_CP_W     = 12,
    parameter int MAX_SYM_W    = 8
) (
    input  logic                    ce_clk,
    input  logic                    ce_rst,
    input  logic [MAX_FFT_LOG2:0]   cfg_fft_len,
    input  logic [MAX_CP_W-1:0]     cfg_cp_len,
    input  logic [MAX_SYM_W-1:0]    cfg_num_symbols,
    input  logic [31:0]             s_axis_tdata,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [31:0]             m_axis_tdata,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic [15:0]             frame_count,
    output logic [15:0]             overlap_count
);

    localparam int c_FFT_W = MAX_FFT_LOG2 + 1;
    // Sample counter must hold both the largest FFT index and the largest CP.
    localparam int c_CNT_W = (c_FFT_W > MAX_CP_W) ? c_FFT_W : MAX_CP_W;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SKIP = 2'd1;
    localparam logic [1:0] c_ST_PASS = 2'd2;

    logic [1:0]             r_state;
    logic [c_FFT_W-1:0]     r_fft_len;
    logic [MAX_CP_W-1:0]    r_cp_len;
    logic [MAX_SYM_W-1:0]   r_num_sym;
    logic [MAX_SYM_W-1:0]   r_sym_cnt;
    logic [c_CNT_W-1:0]     r_samp_cnt;
    logic                   r_first;

    logic [31:0]            r_m_tdata;
    logic                   r_m_tuser;
    logic                   r_m_tlast;
    logic                   r_m_tvalid;
    logic [15:0]            r_frame_count;
    logic [15:0]            r_overlap_count;

    logic                   w_s_ready;
    logic                   w_accept;
    logic                   w_overlap;
    logic [c_CNT_W-1:0]     w_samp_inc;
    logic                   w_cp_done;
    logic                   w_body_last;
    logic [MAX_SYM_W:0]     w_sym_inc;
    logic                   w_frame_done;

    // Only the body pass-through can stall; CP and idle samples are sunk.
    assign w_s_ready    = (r_state != c_ST_PASS) || !r_m_tvalid || m_axis_tready;
    assign w_accept     = s_axis_tvalid && w_s_ready;
    assign w_overlap    = w_accept && s_axis_tuser && (r_state != c_ST_IDLE);

    assign w_samp_inc   = r_samp_cnt + 1'b1;
    assign w_cp_done    = (w_samp_inc == c_CNT_W'(r_cp_len));
    assign w_body_last  = (r_samp_cnt == (c_CNT_W'(r_fft_len) - 1'b1));
    assign w_sym_inc    = {1'b0, r_sym_cnt} + 1'b1;
    assign w_frame_done = (w_sym_inc == {1'b0, r_num_sym});

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            r_state         <= c_ST_IDLE;
            r_fft_len       <= '0;
            r_cp_len        <= '0;
            r_num_sym       <= '0;
            r_sym_cnt       <= '0;
            r_samp_cnt      <= '0;
            r_first         <= 1'b0;
            r_m_tdata       <= '0;
            r_m_tuser       <= 1'b0;
            r_m_tlast       <= 1'b0;
            r_m_tvalid      <= 1'b0;
            r_frame_count   <= '0;
            r_overlap_count <= '0;
        end else begin
            if (r_m_tvalid && m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end

            if (w_overlap && (r_overlap_count != 16'hFFFF)) begin
                r_overlap_count <= r_overlap_count + 1'b1;
            end

            if (w_accept) begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (s_axis_tuser) begin
                            r_fft_len     <= cfg_fft_len;
                            r_cp_len      <= cfg_cp_len;
                            r_num_sym     <= (cfg_num_symbols == '0) ? MAX_SYM_W'(1) : cfg_num_symbols;
                            r_frame_count <= r_frame_count + 1'b1;
                            r_sym_cnt     <= '0;
                            if (cfg_cp_len == '0) begin
                                // Trigger beat is body sample 0; FFT length is
                                // at least 8 so it can never carry tlast.
                                r_m_tvalid <= 1'b1;
                                r_m_tdata  <= s_axis_tdata;
                                r_m_tuser  <= 1'b1;
                                r_m_tlast  <= 1'b0;
                                r_first    <= 1'b0;
                                r_samp_cnt <= c_CNT_W'(1);
                                r_state    <= c_ST_PASS;
                            end else if (cfg_cp_len == MAX_CP_W'(1)) begin
                                // The trigger beat was the whole prefix.
                                r_first    <= 1'b1;
                                r_samp_cnt <= '0;
                                r_state    <= c_ST_PASS;
                            end else begin
                                r_first    <= 1'b1;
                                r_samp_cnt <= c_CNT_W'(1);
                                r_state    <= c_ST_SKIP;
                            end
                        end
                    end

                    c_ST_SKIP: begin
                        if (w_cp_done) begin
                            r_samp_cnt <= '0;
                            r_state    <= c_ST_PASS;
                        end else begin
                            r_samp_cnt <= w_samp_inc;
                        end
                    end

                    c_ST_PASS: begin
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= s_axis_tdata;
                        r_m_tuser  <= r_first;
                        r_m_tlast  <= w_body_last;
                        r_first    <= 1'b0;
                        if (w_body_last) begin
                            r_sym_cnt  <= w_sym_inc[MAX_SYM_W-1:0];
                            r_samp_cnt <= '0;
                            if (w_frame_done) begin
                                r_state <= c_ST_IDLE;
                            end else if (r_cp_len == '0) begin
                                r_state <= c_ST_PASS;
                            end else begin
                                r_state <= c_ST_SKIP;
                            end
                        end else begin
                            r_samp_cnt <= w_samp_inc;
                        end
                    end

                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign s_axis_tready = w_s_ready;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tuser  = r_m_tuser;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tvalid = r_m_tvalid;
    assign busy          = (r_state != c_ST_IDLE);
    assign frame_count   = r_frame_count;
    assign overlap_count = r_overlap_count;

endmodule

`default_nettype wire

// File: tb/tb_ofdm_cp_remover.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofdm_cp_remover
// Description : Directed self-checking bench for ofdm_cp_remover. Ramp input
//               streams with triggers are driven; captured output beats are
//               compared against a frame model built from the config.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ofdm_cp_remover;

    logic        ce_clk = 1'b0;
    logic        ce_rst = 1'b1;
    logic [12:0] cfg_fft_len = 13'd16;
    logic [11:0] cfg_cp_len = 12'd4;
    logic [7:0]  cfg_num_symbols = 8'd2;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] overlap_count;

    int total = 0;
    int bad   = 0;

    logic [33:0] got[$];
    logic [33:0] exp_q[$];

    ofdm_cp_remover #(
        .MAX_FFT_LOG2 (12),
        .MAX_CP_W     (12),
        .MAX_SYM_W    (8)
    ) dut (
        .ce_clk          (ce_clk),
        .ce_rst          (ce_rst),
        .cfg_fft_len     (cfg_fft_len),
        .cfg_cp_len      (cfg_cp_len),
        .cfg_num_symbols (cfg_num_symbols),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .busy            (busy),
        .frame_count     (frame_count),
        .overlap_count   (overlap_count)
    );

    always #5 ce_clk = ~ce_clk;

    // Inputs change 2 time units after the rising edge, so the falling edge
    // sees exactly the values that transfer on the next rising edge.
    always @(negedge ce_clk) begin
        if (!ce_rst && m_axis_tvalid && m_axis_tready) begin
            got.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        end
    end

    function automatic logic [31:0] samp(input int i);
        logic [15:0] v;
        v = i[15:0];
        return {v, 16'hA000 + v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected body beats: symbol s, body sample k sits at input index
    // trig + cp + s*(fft+cp) + k.
    task automatic build_exp(input int trig, input int fft, input int cp, input int nsym);
        exp_q.delete();
        for (int s = 0; s < nsym; s++) begin
            for (int k = 0; k < fft; k++) begin
                exp_q.push_back({(s == 0 && k == 0), (k == fft - 1),
                                 samp(trig + cp + s * (fft + cp) + k)});
            end
        end
    endtask

    task automatic check_frame(input string tag, input int n);
        int lim;
        chk({tag, "_len"}, 64'(got.size()), 64'(n));
        lim = (got.size() < n) ? got.size() : n;
        for (int i = 0; i < lim; i++) begin
            chk($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp_q[i]));
        end
    endtask

    task automatic do_reset();
        @(posedge ce_clk);
        #2 ce_rst = 1'b1;
        @(posedge ce_clk);
        #2 ce_rst = 1'b0;
        got.delete();
    endtask

    // Drive ramp samples 0..n-1; t1/t2 carry tuser. Optional random
    // back-pressure / input gaps, early stop once enough outputs were seen,
    // and a config change once sample chg_idx is being offered.
    task automatic drive(input int n, input int t1, input int t2, input bit bp,
                         input int stop_after, input int chg_idx, input logic [12:0] chg_fft);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < n) begin
            @(posedge ce_clk);
            #2;
            if (stop_after > 0 && got.size() >= stop_after) begin
                s_axis_tvalid = 1'b0;
                s_axis_tuser  = 1'b0;
                return;
            end
            if (chg_idx >= 0 && i == chg_idx) cfg_fft_len = chg_fft;
            m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tvalid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tdata  = samp(i);
            s_axis_tuser  = (i == t1) || (i == t2);
            #1;
            if (s_axis_tvalid && s_axis_tready) i++;
            cyc++;
            if (cyc > 5000) begin
                total++;
                bad++;
                $error("FAIL drive_timeout: observed=%0d accepted expected=%0d", i, n);
                break;
            end
        end
        @(posedge ce_clk);
        #2;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (8) @(posedge ce_clk);
        #2;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge ce_clk);
        #2 ce_rst = 1'b0;
        #1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_tuser", 64'(m_axis_tuser), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frames", 64'(frame_count), 64'd0);
        chk("rst_overlap", 64'(overlap_count), 64'd0);
        chk("rst_s_ready", 64'(s_axis_tready), 64'd1);

        // Basic frame: fft=16 cp=4 sym=2, trigger on sample 10
        cfg_fft_len = 13'd16; cfg_cp_len = 12'd4; cfg_num_symbols = 8'd2;
        build_exp(10, 16, 4, 2);
        drive(100, 10, -1, 1'b0, 0, -1, 13'd0);
        check_frame("basic", 32);
        chk("basic_busy", 64'(busy), 64'd0);
        chk("basic_frames", 64'(frame_count), 64'd1);
        chk("basic_overlap", 64'(overlap_count), 64'd0);

        // No prefix: fft=8 cp=0 sym=1, trigger on sample 5
        do_reset();
        cfg_fft_len = 13'd8; cfg_cp_len = 12'd0; cfg_num_symbols = 8'd1;
        build_exp(5, 8, 0, 1);
        drive(20, 5, -1, 1'b0, 0, -1, 13'd0);
        check_frame("nocp", 8);
        chk("nocp_frames", 64'(frame_count), 64'd1);

        // Back-pressure and input gaps
        do_reset();
        cfg_fft_len = 13'd16; cfg_cp_len = 12'd4; cfg_num_symbols = 8'd2;
        build_exp(10, 16, 4, 2);
        drive(100, 10, -1, 1'b1, 0, -1, 13'd0);
        check_frame("bp", 32);
        chk("bp_busy", 64'(busy), 64'd0);

        // Extra trigger mid-frame
        do_reset();
        build_exp(10, 16, 4, 2);
        drive(100, 10, 20, 1'b0, 0, -1, 13'd0);
        check_frame("ovl", 32);
        chk("ovl_overlap", 64'(overlap_count), 64'd1);
        chk("ovl_frames", 64'(frame_count), 64'd1);

        // Reset mid-frame after output sample 20 (7th body beat)
        do_reset();
        build_exp(10, 16, 4, 2);
        drive(100, 10, -1, 1'b0, 7, -1, 13'd0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("midrst_pre[%0d]", i), 64'(got[i]), 64'(exp_q[i]));
        end
        @(posedge ce_clk);
        #2 ce_rst = 1'b1;
        @(posedge ce_clk);
        #2 ce_rst = 1'b0;
        #1;
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_frames", 64'(frame_count), 64'd0);
        got.delete();
        drive(100, 10, -1, 1'b0, 0, -1, 13'd0);
        check_frame("midrst_post", 32);

        // Config change mid-frame takes effect only on the next frame
        do_reset();
        cfg_fft_len = 13'd16;
        build_exp(10, 16, 4, 2);
        drive(100, 10, -1, 1'b0, 0, 20, 13'd32);
        check_frame("cfgchg_a", 32);
        got.delete();
        build_exp(3, 32, 4, 2);
        drive(100, 3, -1, 1'b0, 0, -1, 13'd0);
        check_frame("cfgchg_b", 64);
        chk("cfgchg_frames", 64'(frame_count), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
